// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: MD opcode encodings, FSM states
// and the latency counter sizing helper.
package mdu_pkg;

  typedef enum logic [2:0] {
    MdNone  = 3'd0,
    MdMult  = 3'd1,
    MdMultu = 3'd2,
    MdDiv   = 3'd3,
    MdDivu  = 3'd4,
    MdMthi  = 3'd5,
    MdMtlo  = 3'd6,
    MdRsvd  = 3'd7
  } mdop_e;

  typedef enum logic {
    StIdle = 1'b0,
    StRun  = 1'b1
  } state_e;

  // Counter must hold the larger of the two latencies.
  function automatic int unsigned cnt_width(input int unsigned mul_lat,
                                            input int unsigned div_lat);
    int unsigned max_lat;
    max_lat = (mul_lat > div_lat) ? mul_lat : div_lat;
    return $clog2(max_lat + 1);
  endfunction

endpackage

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers. The result is
// computed at accept, held, and committed after MUL_LAT/DIV_LAT busy cycles.
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       MDop,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int unsigned CntW = cnt_width(MUL_LAT, DIV_LAT);
  localparam logic [WIDTH-1:0] MostNeg = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] One     = {{(WIDTH-1){1'b0}}, 1'b1};

  state_e           state;
  logic [CntW-1:0]  cnt;
  logic [WIDTH-1:0] hold_hi;
  logic [WIDTH-1:0] hold_lo;
  logic             hold_wr;

  logic [2*WIDTH-1:0]      prod_s;
  logic [2*WIDTH-1:0]      prod_u;
  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s_safe;
  logic signed [WIDTH-1:0] quot_s;
  logic signed [WIDTH-1:0] rem_s;
  logic [WIDTH-1:0]        b_u_safe;
  logic [WIDTH-1:0]        quot_u;
  logic [WIDTH-1:0]        rem_u;
  logic                    div_zero;
  logic                    div_ovf;

  logic             acc;
  logic [CntW-1:0]  acc_lat;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;
  logic             res_wr;

  assign prod_s = $signed({{WIDTH{SrcA[WIDTH-1]}}, SrcA}) *
                  $signed({{WIDTH{SrcB[WIDTH-1]}}, SrcB});
  assign prod_u = {{WIDTH{1'b0}}, SrcA} * {{WIDTH{1'b0}}, SrcB};

  assign div_zero = (SrcB == '0);
  assign div_ovf  = (SrcA == MostNeg) && (SrcB == '1);

  // Substitute a divisor of one for the cases handled separately so the dividers
  // never see x/0 or the signed overflow.
  assign a_s      = $signed(SrcA);
  assign b_s_safe = (div_zero || div_ovf) ? $signed(One) : $signed(SrcB);
  assign b_u_safe = div_zero ? One : SrcB;
  assign quot_s   = a_s / b_s_safe;
  assign rem_s    = a_s % b_s_safe;
  assign quot_u   = SrcA / b_u_safe;
  assign rem_u    = SrcA % b_u_safe;

  always_comb begin
    acc     = 1'b0;
    acc_lat = '0;
    res_hi  = '0;
    res_lo  = '0;
    res_wr  = 1'b0;
    unique case (mdop_e'(MDop))
      MdMult: begin
        acc     = 1'b1;
        acc_lat = CntW'(MUL_LAT);
        res_hi  = prod_s[2*WIDTH-1:WIDTH];
        res_lo  = prod_s[WIDTH-1:0];
        res_wr  = 1'b1;
      end
      MdMultu: begin
        acc     = 1'b1;
        acc_lat = CntW'(MUL_LAT);
        res_hi  = prod_u[2*WIDTH-1:WIDTH];
        res_lo  = prod_u[WIDTH-1:0];
        res_wr  = 1'b1;
      end
      MdDiv: begin
        acc     = 1'b1;
        acc_lat = CntW'(DIV_LAT);
        res_wr  = !div_zero;
        if (div_ovf) begin
          res_hi = '0;
          res_lo = MostNeg;
        end else begin
          res_hi = rem_s;
          res_lo = quot_s;
        end
      end
      MdDivu: begin
        acc     = 1'b1;
        acc_lat = CntW'(DIV_LAT);
        res_wr  = !div_zero;
        res_hi  = rem_u;
        res_lo  = quot_u;
      end
      default: ;
    endcase
  end

  assign busy = (state == StRun);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= StIdle;
      cnt     <= '0;
      hold_hi <= '0;
      hold_lo <= '0;
      hold_wr <= 1'b0;
      HI      <= '0;
      LO      <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (start && acc) begin
            state   <= StRun;
            cnt     <= acc_lat;
            hold_hi <= res_hi;
            hold_lo <= res_lo;
            hold_wr <= res_wr;
          end else if (start && mdop_e'(MDop) == MdMthi) begin
            HI <= SrcA;
          end else if (start && mdop_e'(MDop) == MdMtlo) begin
            LO <= SrcA;
          end
        end
        StRun: begin
          // start is ignored here: the hazard unit should never issue while busy.
          cnt <= cnt - CntW'(1);
          if (cnt == CntW'(1)) begin
            state <= StIdle;
            if (hold_wr) begin
              HI <= hold_hi;
              LO <= hold_lo;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed cases plus randomized ops checked against a
// magnitude-and-sign reference model of HI/LO and busy timing.
module tb_mdu;

  localparam int unsigned W  = 32;
  localparam int unsigned ML = 5;
  localparam int unsigned DL = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [2:0]    MDop;
  logic [W-1:0]  SrcA;
  logic [W-1:0]  SrcB;
  logic          busy;
  logic [W-1:0]  HI;
  logic [W-1:0]  LO;

  int n_checks = 0;
  int n_fails  = 0;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  mdu #(.WIDTH(W), .MUL_LAT(ML), .DIV_LAT(DL)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .MDop  (MDop),
    .SrcA  (SrcA),
    .SrcB  (SrcB),
    .busy  (busy),
    .HI    (HI),
    .LO    (LO)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Reference: multiply/divide magnitudes as unsigned numbers, then apply signs.
  function automatic void model(input logic [2:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] hi_in,
                                input logic [31:0] lo_in, output logic [31:0] hi,
                                output logic [31:0] lo);
    logic        sgn, na, nb;
    logic [31:0] ma, mb, uq, ur, q, r;
    logic [63:0] p;
    hi  = hi_in;
    lo  = lo_in;
    sgn = (op == 3'd1) || (op == 3'd3);
    na  = sgn && a[31];
    nb  = sgn && b[31];
    ma  = na ? -a : a;
    mb  = nb ? -b : b;
    case (op)
      3'd1, 3'd2: begin
        p  = {32'd0, ma} * {32'd0, mb};
        if (na ^ nb) p = -p;
        hi = p[63:32];
        lo = p[31:0];
      end
      3'd3, 3'd4: begin
        if (b != 32'd0) begin
          uq = ma / mb;
          ur = ma % mb;
          q  = (na ^ nb) ? -uq : uq;
          r  = na ? -ur : ur;
          hi = r;
          lo = q;
        end
      end
      3'd5: hi = a;
      3'd6: lo = a;
      default: ;
    endcase
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] nh, nl;
    int lat;
    model(op, a, b, exp_hi, exp_lo, nh, nl);
    lat = (op == 3'd1 || op == 3'd2) ? ML : (op == 3'd3 || op == 3'd4) ? DL : 0;
    @(negedge clk);
    start = 1'b1; MDop = op; SrcA = a; SrcB = b;
    @(negedge clk);
    start = 1'b0; MDop = 3'd0; SrcA = $urandom; SrcB = $urandom;
    for (int i = 0; i < lat; i++) begin
      check("busy_during_op", {31'd0, busy}, 32'd1);
      check("hi_held", HI, exp_hi);
      check("lo_held", LO, exp_lo);
      @(negedge clk);
    end
    exp_hi = nh;
    exp_lo = nl;
    check("busy_after_op", {31'd0, busy}, 32'd0);
    check("hi_result", HI, exp_hi);
    check("lo_result", LO, exp_lo);
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    reset = 1'b1; start = 1'b0; MDop = 3'd0; SrcA = '0; SrcB = '0;
    exp_hi = '0; exp_lo = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_hi", HI, 32'd0);
    check("reset_lo", LO, 32'd0);

    run_op(3'd1, 32'hFFFF_FFFF, 32'd2);
    check("mult_hi_const", HI, 32'hFFFF_FFFF);
    check("mult_lo_const", LO, 32'hFFFF_FFFE);
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2);
    check("multu_hi_const", HI, 32'h0000_0001);
    check("multu_lo_const", LO, 32'hFFFF_FFFE);
    run_op(3'd3, -32'd7, 32'd2);
    check("div_lo_const", LO, 32'hFFFF_FFFD);
    check("div_hi_const", HI, 32'hFFFF_FFFF);
    run_op(3'd4, 32'd7, 32'd2);
    check("divu_lo_const", LO, 32'd3);
    check("divu_hi_const", HI, 32'd1);
    run_op(3'd5, 32'h1234_5678, 32'd0);
    run_op(3'd6, 32'h9ABC_DEF0, 32'd0);
    check("mt_hi_const", HI, 32'h1234_5678);
    check("mt_lo_const", LO, 32'h9ABC_DEF0);

    run_op(3'd5, 32'h0000_AAAA, 32'd0);
    run_op(3'd6, 32'h0000_5555, 32'd0);
    run_op(3'd3, 32'd5, 32'd0);
    check("divzero_hi", HI, 32'h0000_AAAA);
    check("divzero_lo", LO, 32'h0000_5555);
    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_ovf_lo", LO, 32'h8000_0000);
    check("div_ovf_hi", HI, 32'd0);

    run_op(3'd0, 32'h1111_1111, 32'd3);
    run_op(3'd7, 32'h2222_2222, 32'd3);

    // start while busy must be ignored
    @(negedge clk);
    start = 1'b1; MDop = 3'd1; SrcA = 32'd3; SrcB = 32'd4;
    @(negedge clk);
    start = 1'b0;
    check("ign_busy1", {31'd0, busy}, 32'd1);
    @(negedge clk);
    start = 1'b1; MDop = 3'd3; SrcA = 32'd100; SrcB = 32'd7;
    @(negedge clk);
    MDop = 3'd6; SrcA = 32'h0000_DEAD;
    @(negedge clk);
    start = 1'b0; MDop = 3'd0;
    check("ign_busy4", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("ign_busy5", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("ign_done_busy", {31'd0, busy}, 32'd0);
    check("ign_hi", HI, 32'd0);
    check("ign_lo", LO, 32'd12);
    exp_hi = 32'd0; exp_lo = 32'd12;
    @(negedge clk);
    check("ign_no_late_busy", {31'd0, busy}, 32'd0);
    check("ign_no_late_lo", LO, 32'd12);

    // reset in the middle of a divide discards it
    run_op(3'd5, 32'hCAFE_0001, 32'd0);
    @(negedge clk);
    start = 1'b1; MDop = 3'd4; SrcA = 32'd100; SrcB = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_hi = '0; exp_lo = '0;
    check("rst_run_busy", {31'd0, busy}, 32'd0);
    check("rst_run_hi", HI, 32'd0);
    check("rst_run_lo", LO, 32'd0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("rst_no_late_busy", {31'd0, busy}, 32'd0);
      check("rst_no_late_hi", HI, 32'd0);
      check("rst_no_late_lo", LO, 32'd0);
    end

    // reset and start together: reset wins
    run_op(3'd6, 32'h0BAD_F00D, 32'd0);
    @(negedge clk);
    reset = 1'b1; start = 1'b1; MDop = 3'd1; SrcA = 32'd9; SrcB = 32'd9;
    @(negedge clk);
    reset = 1'b0; start = 1'b0; MDop = 3'd0;
    exp_hi = '0; exp_lo = '0;
    check("rst_start_busy", {31'd0, busy}, 32'd0);
    check("rst_start_lo", LO, 32'd0);

    for (int k = 0; k < 60; k++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: ra = 32'h8000_0000;
        3: rb = 32'($urandom_range(1, 15));
        default: ;
      endcase
      run_op(rop, ra, rb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
